// File: rtl/ycr1_wbb_burst_split.sv
// Slave-domain stage of the burst Wishbone bridge: each upstream burst is replayed
// as single-beat classic cycles. Define YCR1_WBB_TIMEOUT_EN to add a downstream ack timeout.
module ycr1_wbb_burst_split #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BW  = 4,
  parameter int BL  = 10,
  parameter int TMO = 255
) (
  input  logic          wbs_clk_i,
  input  logic          wbs_rst_n,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic          wbs_we_i,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic [BW-1:0] wbs_sel_i,
  input  logic [BL-1:0] wbs_bl_i,
  input  logic          wbs_bry_i,
  output logic [DW-1:0] wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_lack_o,
  output logic          wbs_err_o,
  output logic          wbd_cyc_o,
  output logic          wbd_stb_o,
  output logic [AW-1:0] wbd_adr_o,
  output logic          wbd_we_o,
  output logic [DW-1:0] wbd_dat_o,
  output logic [BW-1:0] wbd_sel_o,
  input  logic [DW-1:0] wbd_dat_i,
  input  logic          wbd_ack_i,
  input  logic          wbd_err_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_WAIT} state_t;

  state_t        state_reg;
  logic [BL-1:0] cnt_reg;
  logic [AW-1:0] adr_reg;
  logic          we_reg;
  logic [BW-1:0] sel_reg;
  logic [DW-1:0] wdat_reg;
  logic [DW-1:0] rdat_reg;
  logic          ack_reg;
  logic          lack_reg;
  logic          err_reg;
  logic          stb_reg;
  logic          last_beat;

  assign last_beat = (cnt_reg == BL'(1));

`ifdef YCR1_WBB_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TMO + 1);
  localparam int TW = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
  localparam logic [DW-1:0] TMO_DATA = (DW == 32) ? DW'(32'hDEAD_BEEF) : {DW{1'b1}};

  logic [TW-1:0] tmo_reg;
  logic          tmo_hit;

  assign tmo_hit = (tmo_reg == TW'(TMO));
`endif

  always_ff @(posedge wbs_clk_i) begin
    if (!wbs_rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      adr_reg   <= '0;
      we_reg    <= 1'b0;
      sel_reg   <= '0;
      wdat_reg  <= '0;
      rdat_reg  <= '0;
      ack_reg   <= 1'b0;
      lack_reg  <= 1'b0;
      err_reg   <= 1'b0;
      stb_reg   <= 1'b0;
`ifdef YCR1_WBB_TIMEOUT_EN
      tmo_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (wbs_cyc_i && wbs_stb_i && wbs_bry_i) begin
            adr_reg   <= wbs_adr_i;
            we_reg    <= wbs_we_i;
            sel_reg   <= wbs_sel_i;
            if (wbs_we_i) wdat_reg <= wbs_dat_i;
            // A zero burst length still moves one beat.
            cnt_reg   <= (wbs_bl_i == '0) ? BL'(1) : wbs_bl_i;
            stb_reg   <= 1'b1;
            state_reg <= S_REQ;
`ifdef YCR1_WBB_TIMEOUT_EN
            tmo_reg   <= '0;
`endif
          end
        end
        S_REQ: begin
          if (wbd_ack_i || wbd_err_i) begin
            if (!we_reg) rdat_reg <= wbd_dat_i;
            err_reg   <= wbd_err_i;
            ack_reg   <= 1'b1;
            lack_reg  <= last_beat;
            stb_reg   <= 1'b0;
            state_reg <= S_ACK;
          end
`ifdef YCR1_WBB_TIMEOUT_EN
          else if (tmo_hit) begin
            rdat_reg  <= TMO_DATA;
            err_reg   <= 1'b1;
            ack_reg   <= 1'b1;
            lack_reg  <= last_beat;
            stb_reg   <= 1'b0;
            state_reg <= S_ACK;
          end else begin
            tmo_reg   <= tmo_reg + 1'b1;
          end
`endif
        end
        S_ACK: begin
          ack_reg   <= 1'b0;
          lack_reg  <= 1'b0;
          err_reg   <= 1'b0;
          cnt_reg   <= cnt_reg - 1'b1;
          adr_reg   <= adr_reg + AW'(BW);
          state_reg <= last_beat ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (wbs_cyc_i && wbs_bry_i) begin
            // Write beats after the first come from the upstream command FIFO.
            if (we_reg) begin
              wdat_reg <= wbs_dat_i;
              sel_reg  <= wbs_sel_i;
            end
            stb_reg   <= 1'b1;
            state_reg <= S_REQ;
`ifdef YCR1_WBB_TIMEOUT_EN
            tmo_reg   <= '0;
`endif
          end else if (!wbs_cyc_i) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign wbs_dat_o  = rdat_reg;
  assign wbs_ack_o  = ack_reg;
  assign wbs_lack_o = lack_reg;
  assign wbs_err_o  = err_reg;
  assign wbd_cyc_o  = stb_reg;
  assign wbd_stb_o  = stb_reg;
  assign wbd_adr_o  = adr_reg;
  assign wbd_we_o   = we_reg;
  assign wbd_dat_o  = wdat_reg;
  assign wbd_sel_o  = sel_reg;

endmodule

// File: tb/tb_ycr1_wbb_burst_split.sv
// Directed bench for ycr1_wbb_burst_split: scoreboard queues for downstream requests
// and upstream beat responses, with a scripted downstream responder.
module tb_ycr1_wbb_burst_split;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we, bry;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [9:0]  bl;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_lack_o, wbs_err_o;
  logic        wbd_cyc_o, wbd_stb_o, wbd_we_o;
  logic [31:0] wbd_adr_o, wbd_dat_o;
  logic [3:0]  wbd_sel_o;
  logic [31:0] wbd_dat_i;
  logic        wbd_ack_i, wbd_err_i;

  ycr1_wbb_burst_split #(.AW(32), .DW(32), .BW(4), .BL(10), .TMO(8)) dut (
    .wbs_clk_i (clk),       .wbs_rst_n (rst_n),
    .wbs_cyc_i (cyc),       .wbs_stb_i (stb),
    .wbs_adr_i (adr),       .wbs_we_i  (we),
    .wbs_dat_i (dat),       .wbs_sel_i (sel),
    .wbs_bl_i  (bl),        .wbs_bry_i (bry),
    .wbs_dat_o (wbs_dat_o), .wbs_ack_o (wbs_ack_o),
    .wbs_lack_o(wbs_lack_o),.wbs_err_o (wbs_err_o),
    .wbd_cyc_o (wbd_cyc_o), .wbd_stb_o (wbd_stb_o),
    .wbd_adr_o (wbd_adr_o), .wbd_we_o  (wbd_we_o),
    .wbd_dat_o (wbd_dat_o), .wbd_sel_o (wbd_sel_o),
    .wbd_dat_i (wbd_dat_i), .wbd_ack_i (wbd_ack_i),
    .wbd_err_i (wbd_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [31:0] adr; logic we; logic [31:0] dat; logic [3:0] sel;} req_t;
  typedef struct {logic [31:0] dat; logic err; logic lack; logic chk;} rsp_t;
  typedef struct {logic [31:0] dat; logic ack; logic err; int dly;} dn_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  dn_t  dn_q[$];

  int   errors = 0;
  int   checks = 0;
  logic tmo_expect = 1'b0;

  logic [31:0] b_wd[8], b_rd[8];
  logic [3:0]  b_ws[8];
  logic        b_ack[8], b_err[8];
  int          b_dly[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},  32'(wbs_ack_o),  32'd0);
    check({tag, "_lack"}, 32'(wbs_lack_o), 32'd0);
    check({tag, "_err"},  32'(wbs_err_o),  32'd0);
    check({tag, "_rdat"}, wbs_dat_o,       32'd0);
    check({tag, "_cyc"},  32'(wbd_cyc_o),  32'd0);
    check({tag, "_stb"},  32'(wbd_stb_o),  32'd0);
    check({tag, "_adr"},  wbd_adr_o,       32'd0);
    check({tag, "_we"},   32'(wbd_we_o),   32'd0);
    check({tag, "_wdat"}, wbd_dat_o,       32'd0);
    check({tag, "_sel"},  32'(wbd_sel_o),  32'd0);
  endtask

  // Downstream peripheral: answers each new strobe after its scripted delay.
  initial begin
    dn_t cur;
    int  dly;
    logic srv;
    wbd_ack_i = 1'b0; wbd_err_i = 1'b0; wbd_dat_i = '0; srv = 1'b0; dly = 0;
    cur = '{32'h0, 1'b1, 1'b0, 0};
    forever begin
      @(negedge clk);
      wbd_ack_i = 1'b0;
      wbd_err_i = 1'b0;
      if (!wbd_stb_o) begin
        srv = 1'b0;
      end else begin
        if (!srv) begin
          srv = 1'b1;
          if (dn_q.size() > 0) cur = dn_q.pop_front();
          else cur = '{32'h0, 1'b1, 1'b0, 0};
          dly = cur.dly;
        end
        if (dly == 0) begin
          wbd_ack_i = cur.ack;
          wbd_err_i = cur.err;
          wbd_dat_i = cur.dat;
        end else begin
          dly--;
        end
      end
    end
  end

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    logic prev_stb, hs;
    req_t r;
    rsp_t s;
    prev_stb = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        hs = prev_stb && (wbd_ack_i || wbd_err_i);
        if ((hs || wbs_ack_o) && !tmo_expect)
          check("ack_latency", 32'(wbs_ack_o), 32'(hs));
        if (wbd_stb_o && !prev_stb) begin
          check("cyc_with_stb", 32'(wbd_cyc_o), 32'd1);
          if (req_q.size() == 0) begin
            check("req_unexpected", 32'(wbd_stb_o), 32'd0);
          end else begin
            r = req_q.pop_front();
            check("wbd_adr", wbd_adr_o, r.adr);
            check("wbd_we", 32'(wbd_we_o), 32'(r.we));
            check("wbd_sel", 32'(wbd_sel_o), 32'(r.sel));
            if (r.we) check("wbd_dat", wbd_dat_o, r.dat);
          end
        end
        if (wbs_ack_o) begin
          check("stb_low_on_ack", 32'(wbd_stb_o), 32'd0);
          if (rsp_q.size() == 0) begin
            check("ack_unexpected", 32'(wbs_ack_o), 32'd0);
          end else begin
            s = rsp_q.pop_front();
            check("wbs_err", 32'(wbs_err_o), 32'(s.err));
            check("wbs_lack", 32'(wbs_lack_o), 32'(s.lack));
            if (s.chk) check("wbs_dat", wbs_dat_o, s.dat);
          end
          $display("beat: adr=%h dat=%h err=%0d lack=%0d", wbd_adr_o, wbs_dat_o, wbs_err_o, wbs_lack_o);
        end else begin
          check("lack_without_ack", 32'(wbs_lack_o), 32'd0);
        end
      end
      prev_stb = wbd_stb_o;
    end
  end

  task automatic set_beat(input int i, input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] rd, input logic a, input logic e, input int d);
    b_wd[i] = wd; b_ws[i] = ws; b_rd[i] = rd; b_ack[i] = a; b_err[i] = e; b_dly[i] = d;
  endtask

  task automatic run_burst(input logic [31:0] a, input logic w, input logic [9:0] blen,
                           input int gap_at, input int gap_len, input int abort_after);
    int n, beats, k;
    n = (blen == 0) ? 1 : int'(blen);
    beats = (abort_after > 0) ? abort_after : n;
    for (int i = 0; i < beats; i++) begin
      req_q.push_back('{a + 32'(4 * i), w, b_wd[i], w ? b_ws[i] : b_ws[0]});
      rsp_q.push_back('{b_rd[i], b_err[i], (i == n - 1), !w});
      dn_q.push_back('{b_rd[i], b_ack[i], b_err[i], b_dly[i]});
    end
    $display("burst: adr=%h we=%0d bl=%0d beats=%0d", a, w, blen, beats);
    @(negedge clk);
    adr = a; we = w; bl = blen; dat = b_wd[0]; sel = b_ws[0];
    cyc = 1'b1; stb = 1'b1; bry = 1'b1;
    for (int i = 0; i < beats; i++) begin
      k = 0;
      while (!wbs_ack_o && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("ack_seen", 32'(wbs_ack_o), 32'd1);
      if (!wbs_ack_o) begin
        cyc = 1'b0; stb = 1'b0; bry = 1'b0;
        return;
      end
      if (i == beats - 1) begin
        cyc = 1'b0; stb = 1'b0; bry = 1'b0;
      end else begin
        dat = b_wd[i + 1];
        sel = w ? b_ws[i + 1] : b_ws[0];
        if (i + 1 == gap_at) begin
          bry = 1'b0;
          repeat (gap_len) begin
            @(negedge clk);
            check("stb_low_in_gap", 32'(wbd_stb_o), 32'd0);
          end
          bry = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    repeat (12) begin
      @(negedge clk);
      check("idle_no_stb", 32'(wbd_stb_o), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; bry = 1'b0;
    adr = '0; dat = '0; sel = '0; bl = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read, downstream ack 2 cycles after strobe.
    set_beat(0, 32'h0, 4'hF, 32'hA5A5_0001, 1'b1, 1'b0, 2);
    run_burst(32'h100, 1'b0, 10'd1, -1, 0, 0);

    // Read burst of 4 with varying downstream latency.
    for (int i = 0; i < 4; i++) set_beat(i, 32'h0, 4'hF, 32'hB000_0000 + 32'(i), 1'b1, 1'b0, (i * 2) % 3);
    run_burst(32'h200, 1'b0, 10'd4, -1, 0, 0);

    // Write burst of 3 with a 5-cycle bry gap before beat 2.
    set_beat(0, 32'h11, 4'hF, 32'h0, 1'b1, 1'b0, 0);
    set_beat(1, 32'h22, 4'h3, 32'h0, 1'b1, 1'b0, 1);
    set_beat(2, 32'h33, 4'hC, 32'h0, 1'b1, 1'b0, 0);
    run_burst(32'h300, 1'b1, 10'd3, 1, 5, 0);

    // Read burst of 3 with a downstream error on beat 2.
    set_beat(0, 32'h0, 4'hF, 32'hC000_0001, 1'b1, 1'b0, 0);
    set_beat(1, 32'h0, 4'hF, 32'hC000_0002, 1'b0, 1'b1, 1);
    set_beat(2, 32'h0, 4'hF, 32'hC000_0003, 1'b1, 1'b0, 0);
    run_burst(32'h400, 1'b0, 10'd3, -1, 0, 0);

    // Abort after beat 1 of a 4-beat burst: no lack, back to idle.
    for (int i = 0; i < 4; i++) set_beat(i, 32'h0, 4'hF, 32'hD000_0000 + 32'(i), 1'b1, 1'b0, 0);
    run_burst(32'h500, 1'b0, 10'd4, -1, 0, 1);

    // Zero burst length behaves as one beat.
    set_beat(0, 32'h0, 4'h5, 32'hE000_0600, 1'b1, 1'b0, 0);
    run_burst(32'h600, 1'b0, 10'd0, -1, 0, 0);

    // Address wrap, second beat carries ack and err together.
    set_beat(0, 32'h0, 4'hF, 32'hF000_0001, 1'b1, 1'b0, 0);
    set_beat(1, 32'h0, 4'hF, 32'hF000_0002, 1'b1, 1'b1, 0);
    run_burst(32'hFFFF_FFFC, 1'b0, 10'd2, -1, 0, 0);

    // Reset while a request is outstanding.
    $display("burst: reset during request at adr=00000700");
    req_q.push_back('{32'h700, 1'b0, 32'h0, 4'hF});
    dn_q.push_back('{32'h0, 1'b1, 1'b0, 1000});
    @(negedge clk);
    adr = 32'h700; we = 1'b0; bl = 10'd2; sel = 4'hF; cyc = 1'b1; stb = 1'b1; bry = 1'b1;
    k = 0;
    while (!wbd_stb_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("stb_before_reset", 32'(wbd_stb_o), 32'd1);
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; bry = 1'b0;
    @(posedge clk);
    #2;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("no_ack_after_reset", 32'(wbs_ack_o), 32'd0);
    end

    // Operation resumes after reset.
    set_beat(0, 32'h9999_0001, 4'hA, 32'h0, 1'b1, 1'b0, 1);
    run_burst(32'h900, 1'b1, 10'd1, -1, 0, 0);

`ifdef YCR1_WBB_TIMEOUT_EN
    // Downstream never answers: timeout beat 9 cycles after the request starts.
    $display("burst: timeout at adr=00000800");
    tmo_expect = 1'b1;
    req_q.push_back('{32'h800, 1'b0, 32'h0, 4'hF});
    rsp_q.push_back('{32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1});
    dn_q.push_back('{32'h0, 1'b1, 1'b0, 1000});
    @(negedge clk);
    adr = 32'h800; we = 1'b0; bl = 10'd1; sel = 4'hF; cyc = 1'b1; stb = 1'b1; bry = 1'b1;
    k = 0;
    while (!wbd_stb_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    cyc = 1'b0; stb = 1'b0; bry = 1'b0;
    k = 0;
    while (!wbs_ack_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cycles", 32'(k), 32'd9);
    repeat (3) @(negedge clk);
    tmo_expect = 1'b0;
`endif

    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("dn_q_drained", 32'(dn_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
